// File: rtl/i2c_cfg_sequencer.sv
// Codec init sequencer: walks a fixed register table and feeds 24-bit write frames to an I2C controller.
// Optional macro I2C_CFG_RETRY_LIMIT_EN bounds retries per entry and flags skipped entries on cfg_err.
module i2c_cfg_sequencer #(
    parameter logic [7:0] SLAVE_ADDR     = 8'h34,
    parameter int         LUT_SIZE       = 10,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         MAX_RETRY      = 3
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        i2c_end,
    input  logic        i2c_nack,
    output logic        GO,
    output logic [23:0] i2c_data,
    output logic [3:0]  cfg_index,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_PASS  = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'(LUT_SIZE - 1);

    // Table word layout: {reg[6:0], data[8:0]}
    function automatic logic [15:0] f_lut(input logic [3:0] idx);
        logic [15:0] word;
        case (idx)
            4'd0:    word = 16'h001A;
            4'd1:    word = 16'h021A;
            4'd2:    word = 16'h047B;
            4'd3:    word = 16'h067B;
            4'd4:    word = 16'h08F8;
            4'd5:    word = 16'h0A06;
            4'd6:    word = 16'h0C00;
            4'd7:    word = 16'h0E01;
            4'd8:    word = 16'h1002;
            4'd9:    word = 16'h1201;
            default: word = 16'h0000;
        endcase
        return word;
    endfunction

    logic [2:0]       r_state;
    logic [3:0]       r_cfg_index;
    logic [23:0]      r_i2c_data;
    logic             r_go;
    logic [TO_W-1:0]  r_to_cnt;
    logic [GAP_W-1:0] r_gap_cnt;

    logic [2:0]       w_state_next;
    logic [3:0]       w_index_next;
    logic [23:0]      w_data_next;
    logic [TO_W-1:0]  w_to_next;
    logic [GAP_W-1:0] w_gap_next;
    logic             w_advance;
    logic [15:0]      w_lut_word;

`ifdef I2C_CFG_RETRY_LIMIT_EN
    localparam int              RT_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(MAX_RETRY - 1);

    logic [RT_W-1:0] r_retry;
    logic [RT_W-1:0] w_retry_next;
    logic            r_cfg_err;
    logic            w_err_next;
`else
    logic w_unused_retry_cfg;
    assign w_unused_retry_cfg = (MAX_RETRY > 0);
`endif

    assign w_lut_word = f_lut(r_cfg_index);

    always_comb begin
        w_state_next = r_state;
        w_index_next = r_cfg_index;
        w_data_next  = r_i2c_data;
        w_to_next    = r_to_cnt;
        w_gap_next   = r_gap_cnt;
        w_advance    = 1'b0;
`ifdef I2C_CFG_RETRY_LIMIT_EN
        w_retry_next = r_retry;
        w_err_next   = r_cfg_err;
`endif
        case (r_state)
            S_LOAD: begin
                w_data_next  = {SLAVE_ADDR, w_lut_word};
                w_to_next    = '0;
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completion arriving on the timeout cycle still counts as a completion
                if (i2c_end) begin
                    w_state_next = i2c_nack ? S_FAIL : S_PASS;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next = S_FAIL;
                end else begin
                    w_to_next = r_to_cnt + TO_W'(1);
                end
            end
            S_PASS: begin
`ifdef I2C_CFG_RETRY_LIMIT_EN
                w_retry_next = '0;
`endif
                w_advance = 1'b1;
            end
            S_FAIL: begin
`ifdef I2C_CFG_RETRY_LIMIT_EN
                if (r_retry == RT_LAST) begin
                    w_err_next   = 1'b1;
                    w_retry_next = '0;
                    w_advance    = 1'b1;
                end else begin
                    w_retry_next = r_retry + RT_W'(1);
                    w_gap_next   = '0;
                    w_state_next = S_GAP;
                end
`else
                w_gap_next   = '0;
                w_state_next = S_GAP;
`endif
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_next   = '0;
                    w_state_next = S_LOAD;
                end else begin
                    w_gap_next = r_gap_cnt + GAP_W'(1);
                end
            end
            S_DONE: begin
                if (start) begin
                    w_index_next = '0;
`ifdef I2C_CFG_RETRY_LIMIT_EN
                    w_retry_next = '0;
`endif
                    w_state_next = S_LOAD;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase

        if (w_advance) begin
            if (r_cfg_index == LAST_IDX) begin
                w_state_next = S_DONE;
            end else begin
                w_index_next = r_cfg_index + 4'd1;
                w_gap_next   = '0;
                w_state_next = S_GAP;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_cfg_index <= '0;
            r_i2c_data  <= '0;
            r_go        <= 1'b0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cfg_index <= w_index_next;
            r_i2c_data  <= w_data_next;
            r_go        <= (w_state_next == S_ISSUE);
            r_to_cnt    <= w_to_next;
            r_gap_cnt   <= w_gap_next;
        end
    end

`ifdef I2C_CFG_RETRY_LIMIT_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_retry   <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_retry   <= w_retry_next;
            r_cfg_err <= w_err_next;
        end
    end

    assign cfg_err = r_cfg_err;
`else
    assign cfg_err = 1'b0;
`endif

    assign GO        = r_go;
    assign i2c_data  = r_i2c_data;
    assign cfg_index = r_cfg_index;
    assign busy      = (r_state != S_DONE);
    assign cfg_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench for i2c_cfg_sequencer: a scripted controller answers each GO and frame timing is checked.
module tb_i2c_cfg_sequencer;

    logic        CLK;
    logic        reset;
    logic        start;
    logic        i2c_end;
    logic        i2c_nack;
    logic        GO;
    logic [23:0] i2c_data;
    logic [3:0]  cfg_index;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;

    i2c_cfg_sequencer dut (
        .CLK       (CLK),
        .reset     (reset),
        .start     (start),
        .i2c_end   (i2c_end),
        .i2c_nack  (i2c_nack),
        .GO        (GO),
        .i2c_data  (i2c_data),
        .cfg_index (cfg_index),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

`ifdef I2C_CFG_RETRY_LIMIT_EN
    localparam int       N_ATT    = 3;
    localparam logic     EXP_ERR  = 1'b1;
    localparam int       R4_GOS   = 12;
`else
    localparam int       N_ATT    = 5;
    localparam logic     EXP_ERR  = 1'b0;
    localparam int       R4_GOS   = 14;
`endif

    logic [15:0] lut [0:9] = '{16'h001A, 16'h021A, 16'h047B, 16'h067B, 16'h08F8,
                               16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int go_cnt  = 0;
    int last_go = 0;
    int spacing = 0;
    int go_base = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (GO === 1'b1) go_cnt <= go_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_go(input int limit, output bit found);
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            @(negedge CLK);
            if (GO === 1'b1) found = 1'b1;
        end
        if (found) begin
            spacing = cyc - last_go;
            last_go = cyc;
        end
        chk("go_seen", {31'b0, found}, 32'd1);
    endtask

    // Waits for GO, checks the frame, then answers after 'delay' cycles (0 = no answer)
    task automatic do_entry(input string pfx, input int idx, input bit nack, input int delay, input int exp_gap);
        bit          found;
        logic [15:0] word;
        wait_go(exp_gap + 50, found);
        word = lut[idx];
        $display("GO %s idx=%0d data=%h spacing=%0d", pfx, cfg_index, i2c_data, spacing);
        chk($sformatf("%s_e%0d_data", pfx, idx), {8'h0, i2c_data}, {8'h0, 8'h34, word});
        chk($sformatf("%s_e%0d_index", pfx, idx), {28'h0, cfg_index}, 32'(idx));
        chk($sformatf("%s_e%0d_spacing", pfx, idx), 32'(spacing), 32'(exp_gap));
        if (delay > 0) begin
            repeat (delay) @(negedge CLK);
            i2c_nack = nack;
            i2c_end  = 1'b1;
            @(negedge CLK);
            i2c_end  = 1'b0;
            i2c_nack = 1'b0;
        end
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        start   = 1'b1;
        last_go = cyc;
        @(negedge CLK);
        start   = 1'b0;
    endtask

    task automatic check_done(input string pfx, input int exp_gos, input logic exp_err);
        repeat (60) @(negedge CLK);
        chk($sformatf("%s_done", pfx), {31'b0, cfg_done}, 32'd1);
        chk($sformatf("%s_busy", pfx), {31'b0, busy}, 32'd0);
        chk($sformatf("%s_index", pfx), {28'h0, cfg_index}, 32'd9);
        chk($sformatf("%s_gos", pfx), 32'(go_cnt - go_base), 32'(exp_gos));
        chk($sformatf("%s_err", pfx), {31'b0, cfg_err}, {31'b0, exp_err});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        i2c_end  = 1'b0;
        i2c_nack = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_go", {31'b0, GO}, 32'd0);
        chk("rst_data", {8'h0, i2c_data}, 32'h0);
        chk("rst_index", {28'h0, cfg_index}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_done", {31'b0, cfg_done}, 32'd0);
        chk("rst_err", {31'b0, cfg_err}, 32'd0);

        // Run 1: clean pass; start and a stray end injected after entry 5 must be ignored
        go_base = go_cnt;
        reset   = 1'b0;
        last_go = cyc;
        for (int i = 0; i < 10; i++) begin
            do_entry("r1", i, 1'b0, 30, (i == 0) ? 1 : 49);
            if (i == 5) begin
                start = 1'b1;
                @(negedge CLK);
                start    = 1'b0;
                i2c_end  = 1'b1;
                i2c_nack = 1'b1;
                @(negedge CLK);
                i2c_end  = 1'b0;
                i2c_nack = 1'b0;
                chk("r1_busy_after_start", {31'b0, busy}, 32'd1);
            end
        end
        check_done("r1", 10, 1'b0);

        // Run 2: restart from DONE, entry 3 NACKed once
        go_base = go_cnt;
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) do_entry("r2", 3, 1'b1, 30, 49);
            do_entry("r2", i, 1'b0, 30, (i == 0) ? 2 : 49);
            if (i == 0) chk("r2_done_fell", {31'b0, cfg_done}, 32'd0);
        end
        check_done("r2", 11, 1'b0);

        // Run 3: entry 0 never answered, re-sent after the timeout and gap
        go_base = go_cnt;
        start_pulse();
        do_entry("r3", 0, 1'b0, 0, 2);
        for (int i = 0; i < 10; i++) begin
            do_entry("r3", i, 1'b0, 30, (i == 0) ? 4115 : 49);
        end
        check_done("r3", 11, 1'b0);

        // Run 4: entry 2 keeps NACKing
        go_base = go_cnt;
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                for (int a = 0; a < N_ATT; a++) begin
                    do_entry("r4", 2, (EXP_ERR == 1'b1) || (a < N_ATT - 1), 30, 49);
                end
            end else begin
                do_entry("r4", i, 1'b0, 30, (i == 0) ? 2 : 49);
            end
        end
        check_done("r4", R4_GOS, EXP_ERR);

        // Run 5: reset in the middle of the entry 4 wait
        start_pulse();
        chk("r5_err_kept", {31'b0, cfg_err}, {31'b0, EXP_ERR});
        for (int i = 0; i < 4; i++) begin
            do_entry("r5", i, 1'b0, 30, (i == 0) ? 2 : 49);
        end
        do_entry("r5", 4, 1'b0, 0, 49);
        repeat (10) @(negedge CLK);
        reset = 1'b1;
        #1;
        chk("r5_rst_go", {31'b0, GO}, 32'd0);
        chk("r5_rst_data", {8'h0, i2c_data}, 32'h0);
        chk("r5_rst_index", {28'h0, cfg_index}, 32'd0);
        chk("r5_rst_busy", {31'b0, busy}, 32'd1);
        chk("r5_rst_done", {31'b0, cfg_done}, 32'd0);
        chk("r5_rst_err", {31'b0, cfg_err}, 32'd0);
        repeat (2) @(negedge CLK);
        reset   = 1'b0;
        last_go = cyc;
        do_entry("r5post", 0, 1'b0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
